// File: rtl/seq_multiplier.sv
// Iterative radix-2 shift-add multiplier, one multiplier bit per cycle.
// Ports: clk, rst_n (sync, active-low), in_valid/in_ready + A/B/Signed_mode
// in, out_valid/out_ready + Sum out, busy while not IDLE.
module seq_multiplier #(
  parameter int N = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N-1:0]   A,
  input  logic [N-1:0]   B,
  input  logic           Signed_mode,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*N-1:0] Sum,
  output logic           busy
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [N-1:0]   a_mag;
  logic [2*N-1:0] prod;
  logic           neg;
  logic [N:0]     hi_sum;
  logic [2*N-1:0] prod_nx;

  function automatic logic [N-1:0] mag(
    input logic [N-1:0] v,
    input logic         s
  );
    return (s && v[N-1]) ? (~v + 1'b1) : v;
  endfunction

  // prod = {partial, remaining multiplier bits}; add then shift right
  always_comb begin
    hi_sum  = {1'b0, prod[2*N-1:N]}
            + (prod[0] ? {1'b0, a_mag} : '0);
    prod_nx = {hi_sum, prod[N-1:1]};
  end

  assign in_ready = (state == IDLE);
  assign busy     = (state != IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      a_mag     <= '0;
      prod      <= '0;
      neg       <= 1'b0;
      Sum       <= '0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_mag <= mag(A, Signed_mode);
            prod  <= {{N{1'b0}}, mag(B, Signed_mode)};
            neg   <= Signed_mode & (A[N-1] ^ B[N-1]);
            cnt   <= '0;
            state <= CALC;
          end
        end
        CALC: begin
          prod <= prod_nx;
          cnt  <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            // zero magnitude negates to zero, so no negative zero
            Sum       <= neg ? -prod_nx : prod_nx;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_seq_multiplier.sv
// Scoreboard bench for seq_multiplier at N=2,4,8,32 plus directed N=8
// handshake, backpressure and reset checks.
module tb_seq_multiplier;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;
  int ndone = 0;
  logic g_rst = 1'b0;
  bit rel = 1'b0;

  task automatic check(
    input bit          ok,
    input string       nm,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    tests++;
    if (!ok) begin
      fails++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  function automatic logic [63:0] ref_prod(
    input int          w,
    input logic [31:0] a,
    input logic [31:0] b,
    input bit          s
  );
    logic [31:0] mk;
    longint av, bv;
    logic [63:0] p, m;
    mk = (w == 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 1);
    av = longint'({32'b0, a & mk});
    bv = longint'({32'b0, b & mk});
    if (s && a[w-1]) av = av - (longint'(1) << w);
    if (s && b[w-1]) bv = bv - (longint'(1) << w);
    p = av * bv;
    m = (w == 32) ? '1 : ((64'h1 << (2 * w)) - 1);
    return p & m;
  endfunction

  // ---------------- scoreboard instances ----------------
  for (genvar gi = 0; gi < 4; gi++) begin : g
    localparam int W = (gi == 0) ? 2 : (gi == 1) ? 4 :
                       (gi == 2) ? 8 : 32;
    logic iv, ir, s, ov, orr, bz;
    logic [W-1:0] a, b;
    logic [2*W-1:0] sum;
    logic [63:0] exp_q[$];
    int cyc_q[$];

    seq_multiplier #(.N(W)) dut (
      .clk(clk), .rst_n(g_rst), .in_valid(iv),
      .in_ready(ir), .A(a), .B(b),
      .Signed_mode(s), .out_valid(ov),
      .out_ready(orr), .Sum(sum), .busy(bz)
    );

    initial begin : drv
      logic [31:0] qa[$], qb[$];
      bit qs[$];
      logic [31:0] cv[5];
      logic [31:0] mk;
      int t;
      iv = 0; a = '0; b = '0; s = 0;
      mk = (W == 32) ? 32'hFFFF_FFFF : ((32'h1 << W) - 1);
      if (W <= 4) begin
        for (int m = 0; m < 2; m++)
          for (int i = 0; i < (1 << W); i++)
            for (int j = 0; j < (1 << W); j++) begin
              qa.push_back(i); qb.push_back(j); qs.push_back(m[0]);
            end
      end else begin
        cv[0] = 0; cv[1] = 1; cv[2] = mk;
        cv[3] = 32'h1 << (W - 1); cv[4] = mk >> 1;
        for (int m = 0; m < 2; m++)
          for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++) begin
              qa.push_back(cv[i]); qb.push_back(cv[j]);
              qs.push_back(m[0]);
            end
        for (int i = 0; i < 150; i++) begin
          qa.push_back($urandom & mk); qb.push_back($urandom & mk);
          qs.push_back(1'($urandom));
        end
      end
      wait (rel);
      @(negedge clk);
      for (int i = 0; i < qa.size(); i++) begin
        t = 0;
        while (!ir && t < 300) begin
          iv = 1'($urandom); a = W'($urandom);
          b = W'($urandom); s = 1'($urandom);
          @(negedge clk);
          t++;
        end
        if (!ir) begin
          check(0, $sformatf("N%0d accept_timeout", W), 0, 1);
          break;
        end
        a = W'(qa[i]); b = W'(qb[i]); s = qs[i]; iv = 1;
        exp_q.push_back(ref_prod(W, qa[i], qb[i], qs[i]));
        cyc_q.push_back(cyc + 1);
        @(negedge clk);
      end
      iv = 0;
      t = 0;
      while (exp_q.size() != 0 && t < 500) begin
        @(negedge clk);
        t++;
      end
      check(exp_q.size() == 0, $sformatf("N%0d drain", W),
            exp_q.size(), 0);
      ndone++;
    end

    initial begin : mon
      logic pv;
      logic [2*W-1:0] held;
      logic [63:0] e;
      int c;
      pv = 0; held = '0; orr = 1;
      forever begin
        @(negedge clk);
        if (ov && !pv) begin
          if (exp_q.size() == 0) begin
            check(0, $sformatf("N%0d spurious_out", W), 64'(sum), 0);
          end else begin
            e = exp_q.pop_front();
            c = cyc_q.pop_front();
            check(64'(sum) == e, $sformatf("N%0d sum", W), 64'(sum), e);
            check(cyc - c == W, $sformatf("N%0d latency", W),
                  cyc - c, W);
          end
          held = sum;
        end else if (ov && pv) begin
          check(sum == held, $sformatf("N%0d hold", W),
                64'(sum), 64'(held));
        end
        pv = ov;
        orr = 1'($urandom);
      end
    end
  end

  // ---------------- directed N=8 instance ----------------
  logic d_rst, d_iv, d_ir, d_s, d_ov, d_or, d_bz;
  logic [7:0] d_a, d_b;
  logic [15:0] d_sum;

  seq_multiplier #(.N(8)) u_d (
    .clk(clk), .rst_n(d_rst), .in_valid(d_iv),
    .in_ready(d_ir), .A(d_a), .B(d_b),
    .Signed_mode(d_s), .out_valid(d_ov),
    .out_ready(d_or), .Sum(d_sum), .busy(d_bz)
  );

  // called at a negedge; returns at the negedge where out_valid rose
  task automatic go8(
    input logic [7:0]  a,
    input logic [7:0]  b,
    input bit          s,
    input logic [15:0] exp,
    input string       nm
  );
    int lat;
    d_a = a; d_b = b; d_s = s; d_iv = 1;
    @(negedge clk);
    d_iv = 0; d_a = ~a; d_b = ~b; d_s = ~s;
    lat = 0;
    for (int k = 1; k <= 12 && lat == 0; k++) begin
      @(negedge clk);
      if (d_ov) lat = k;
    end
    check(lat == 8, {nm, " latency"}, lat, 8);
    check(d_sum == exp, {nm, " sum"}, d_sum, exp);
    if (d_or) begin
      @(negedge clk);
      check(!d_ov, {nm, " pulse"}, d_ov, 0);
      check(d_ir, {nm, " ready_after"}, d_ir, 1);
    end
  endtask

  initial begin
    int t, seen;
    d_rst = 0; d_iv = 0; d_a = 0; d_b = 0; d_s = 0; d_or = 1;
    repeat (3) @(negedge clk);
    g_rst = 1;
    rel = 1;
    check(!d_ov, "rst out_valid", d_ov, 0);
    check(!d_bz, "rst busy", d_bz, 0);
    check(d_sum == 0, "rst sum", d_sum, 0);
    check(d_ir, "rst in_ready", d_ir, 1);

    d_rst = 1;
    go8(8'hFF, 8'hFF, 0, 16'hFE01, "u_ff_ff");
    go8(8'h80, 8'h80, 1, 16'h4000, "s_80_80");
    go8(8'hFD, 8'h05, 1, 16'hFFF1, "s_fd_05");
    go8(8'hFD, 8'h05, 0, 16'h04F1, "u_fd_05");
    go8(8'h00, 8'h80, 1, 16'h0000, "s_zero");

    d_or = 0;
    go8(8'h12, 8'h34, 0, 16'h03A8, "bp");
    seen = 0;
    for (int k = 0; k < 5; k++) begin
      d_iv = k[0]; d_a = 8'h55; d_b = 8'hAA;
      @(negedge clk);
      if (!d_ov || d_sum != 16'h03A8 || d_ir || !d_bz) seen++;
    end
    check(seen == 0, "bp stall", seen, 0);
    d_iv = 1; d_or = 1;
    @(negedge clk);
    check(!d_ov, "bp release", d_ov, 0);
    check(!d_bz, "bp no_same_edge_accept", d_bz, 0);
    check(d_sum == 16'h03A8, "bp sum_kept", d_sum, 16'h03A8);
    d_iv = 0;
    @(negedge clk);
    check(!d_bz, "bp iv_not_queued", d_bz, 0);

    d_a = 8'h77; d_b = 8'h66; d_s = 0; d_iv = 1;
    @(negedge clk);
    d_iv = 0;
    repeat (2) @(negedge clk);
    d_rst = 0;
    @(negedge clk);
    check(!d_ov, "abort out_valid", d_ov, 0);
    check(!d_bz, "abort busy", d_bz, 0);
    check(d_sum == 0, "abort sum", d_sum, 0);
    check(d_ir, "abort in_ready", d_ir, 1);
    d_rst = 1;
    seen = 0;
    repeat (12) begin
      @(negedge clk);
      if (d_ov || d_sum != 0) seen++;
    end
    check(seen == 0, "abort never_out", seen, 0);

    t = 0;
    while (ndone < 4 && t < 60000) begin
      @(negedge clk);
      t++;
    end
    check(ndone == 4, "sb finish", ndone, 4);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 Parameter N, default 8, operand width in bits; legal range 2..32.
REQ-002 clk  input  1  sole clock; all state changes on rising edge.
REQ-003 rst_n  input  1  reset, synchronous, active-low.
REQ-004 in_valid  input  1  operand pair on A/B/Signed_mode is valid.
REQ-005 in_ready  output  1  block can accept an operand pair.
REQ-006 A  input  N  multiplicand.
REQ-007 B  input  N  multiplier.
REQ-008 Signed_mode  input  1  1 = A/B two's complement, 0 = unsigned; sampled with A/B.
REQ-009 out_valid  output  1  Sum holds a completed product.
REQ-010 out_ready  input  1  consumer accepts Sum.
REQ-011 Sum  output  2N  product.
REQ-012 busy  output  1  high whenever state is not IDLE.

Function
REQ-013 Shall be an iterative radix-2 shift-add multiplier with one operand bit processed per CALC cycle.
REQ-014 States shall be IDLE, CALC and DONE only; any unreachable encoding shall return to IDLE on the next edge.
REQ-015 in_ready shall be 1 in IDLE and 0 in CALC and DONE.
REQ-016 Accept = in_valid && in_ready at a rising edge; on accept, A, B and Signed_mode are latched, the iteration counter is cleared, and state goes IDLE->CALC.
REQ-017 A, B and Signed_mode may change freely after accept without affecting the result.
REQ-018 CALC shall last exactly N cycles; after the Nth CALC edge, state goes to DONE, Sum is loaded and out_valid is 1.
REQ-019 Latency shall be exactly N clock cycles from the accepting edge to the edge at which out_valid rises, independent of operand values (no early termination).
REQ-020 Unsigned mode: Sum = A*B, zero-extended, exact in 2N bits.
REQ-021 Signed mode: operands are converted to N-bit magnitudes; the magnitudes are multiplied unsigned; the 2N-bit result is negated iff exactly one operand is negative.
REQ-022 Signed mode, A = B = -2^(N-1): Sum = +2^(2N-2) with no overflow.
REQ-023 Signed mode, any zero operand: Sum = 0, never a negative zero pattern.
REQ-024 In DONE, out_valid = 1 and Sum is stable until out_ready = 1 is sampled; then state goes DONE->IDLE and out_valid goes to 0.
REQ-025 Leaving DONE shall not accept new operands on the same edge; the earliest next accept is the following edge.
REQ-026 Sum shall keep the last product after the DONE handshake until the next product is loaded.
REQ-027 in_valid asserted during CALC or DONE shall be ignored and shall not queue.
REQ-028 out_ready asserted outside DONE shall have no effect.

Reset
REQ-029 While rst_n = 0 at a rising edge: state becomes IDLE, out_valid = 0, busy = 0, Sum = 0, the counter and internal operand registers = 0, and in_ready = 1 from that edge.
REQ-030 Reset asserted in CALC or DONE shall abort the operation; the aborted product shall never appear on Sum or out_valid.
REQ-031 An accept shall be possible on the first edge with rst_n = 1 after reset.

Verification
REQ-032 N=8 unsigned, A=0xFF, B=0xFF, out_ready=1 -> out_valid rises exactly 8 cycles after accept, Sum=0xFE01, one-cycle pulse, then in_ready=1.
REQ-033 N=8 signed: A=0x80, B=0x80 -> Sum=0x4000; A=0xFD, B=0x05 -> Sum=0xFFF1; same A/B unsigned -> Sum=0x04F1.
REQ-034 N=8 backpressure: out_ready=0 for 5 cycles after out_valid -> Sum and out_valid stable; in_ready=0; in_valid pulses ignored; out_ready=1 -> IDLE next edge.
REQ-035 N=8 reset mid-op: rst_n=0 on the 3rd CALC cycle -> next edge out_valid=0, busy=0, Sum=0, in_ready=1; the aborted product never appears.
REQ-036 N=4 exhaustive: all 256 A/B pairs in both modes, back-to-back accepts -> every Sum matches the reference product (sign-extended for signed), zero mismatches, latency 4 for every pair.
REQ-037 N=2 and N=32 smoke: extreme values (all-ones, most-negative, zero) -> exact products, latency equal to N.
